// File: rtl/gen_output_fifo.sv
// rtl/gen_output_fifo.sv - elastic output buffer for a generator, with done forwarding
//
// Purpose: decouples a generator (_valid/_ready/_done, packed tuple output) from its
// consumer. Tuples are buffered in a show-ahead FIFO. The generator's done pulse is
// forwarded as out_done only once every buffered tuple has been handed over.
//
// Ports:
//   _clock    in   1           clock, all state updates on posedge
//   _reset    in   1           asynchronous active-low reset
//   _start    in   1           synchronous flush (drops contents and any pending done)
//   in_data   in   WIDTH       tuple from generator, element _0 in the LSBs
//   in_valid  in   1           generator valid
//   in_done   in   1           generator done pulse
//   in_ready  out  1           generator ready, high when not full (registered)
//   out_data  out  WIDTH       head entry (registered, show-ahead)
//   out_valid out  1           head entry valid (FIFO non-empty)
//   out_ready in   1           consumer accepts the head entry
//   out_done  out  1           one-cycle pulse: stream finished and fully drained
//   count     out  CW          current occupancy
module gen_output_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     _clock,
  input  logic                     _reset,
  input  logic                     _start,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  input  logic                     in_done,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_STREAM = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_IDLE   = 2'd2
  } state_t;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_done_q;
  state_t           state_q;

  logic push;
  logic pop;

  // in_ready_q is the registered "not full" flag, so a full FIFO refuses a push
  // even when a pop happens in the same cycle.
  assign push = in_valid && in_ready_q && !_start;
  assign pop  = out_valid_q && out_ready && !_start;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    if (_start) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      // The next head slot may be the one being written this cycle (empty FIFO,
      // or a single entry popped while a new one arrives): bypass in_data.
      if (count_d != '0) begin
        if (push && (rd_ptr_d == wr_ptr_q)) out_data_d = in_data;
        else                                out_data_d = mem_q[rd_ptr_d];
      end
    end
    out_valid_d = (count_d != '0);
    in_ready_d  = (count_d != CW'(DEPTH));
  end

  always_ff @(posedge _clock) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_done_q  <= 1'b0;
      state_q     <= ST_STREAM;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      if (_start) begin
        out_done_q <= 1'b0;
        state_q    <= ST_STREAM;
      end else begin
        out_done_q <= 1'b0;
        case (state_q)
          ST_STREAM: if (in_done) state_q <= ST_DRAIN;
          // Further done pulses are ignored while draining; the pulse fires once
          // the FIFO is empty and nothing new is arriving this cycle.
          ST_DRAIN: begin
            if ((count_q == '0) && !push) begin
              out_done_q <= 1'b1;
              state_q    <= ST_IDLE;
            end
          end
          ST_IDLE:   if (in_done) state_q <= ST_DRAIN;
          default:   state_q <= ST_STREAM;
        endcase
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_done  = out_done_q;
  assign count     = count_q;

endmodule

// File: tb/tb_gen_output_fifo.sv
// tb/tb_gen_output_fifo.sv - self-checking bench for gen_output_fifo
module tb_gen_output_fifo;

  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_done = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_done;
  logic [$clog2(D):0] count;

  gen_output_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    ._clock(clk), ._reset(rst_n), ._start(start),
    .in_data(in_data), .in_valid(in_valid), .in_done(in_done), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_done(out_done), .count(count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of buffered tuples plus a "done seen, waiting to drain" flag.
  logic [W-1:0] q[$];
  logic m_ready = 1'b1;
  logic m_pend  = 1'b0;
  logic m_done  = 1'b0;
  logic acc     = 1'b0;
  logic tog     = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ready = 1'b1;
    m_pend  = 1'b0;
    m_done  = 1'b0;
  endtask

  task automatic compare();
    check("in_ready", 64'(in_ready), 64'(m_ready));
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("count", 64'(count), 64'(q.size()));
    check("out_done", 64'(out_done), 64'(m_done));
    if (q.size() != 0) check("out_data", 64'(out_data), 64'(q[0]));
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic dn,
                      input logic st, input logic ordy);
    logic push, pop;
    in_valid = v; in_data = d; in_done = dn; start = st; out_ready = ordy;
    @(posedge clk);
    push = 1'b0;
    if (st) begin
      model_reset();
    end else begin
      push = v && m_ready;
      pop  = (q.size() != 0) && ordy;
      m_done = 1'b0;
      if (m_pend) begin
        if (q.size() == 0 && !push) begin
          m_done = 1'b1;
          m_pend = 1'b0;
        end
      end else if (dn) begin
        m_pend = 1'b1;
      end
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(d);
      m_ready = (q.size() != D);
    end
    acc = push;
    @(negedge clk);
    in_valid = 1'b0; in_done = 1'b0; start = 1'b0;
    compare();
  endtask

  task automatic send(input logic [W-1:0] d, input logic ordy);
    int n = 0;
    do begin
      step(1'b1, d, 1'b0, 1'b0, ordy);
      n++;
    end while (!acc && n < 50);
    check("send_accepted", 64'(acc), 64'd1);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, ordy);
  endtask

  task automatic hrange_0_10_2();
    for (int v = 0; v < 10; v += 2) begin
      send(W'(v), 1'b1);
      check("t1_count_le1", 64'(count <= 1), 64'd1);
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);
  endtask

  initial begin
    // Reset values
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    check("rst_out_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;

    // 1: hrange(0,10,2), consumer always ready
    hrange_0_10_2();

    // 2: consumer stalled, 6 tuples offered, only 4 fit
    for (int i = 0; i < 4; i++) send($urandom, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h5555_0005, 1'b0, 1'b0, 1'b0);
    check("t2_full_ready", 64'(in_ready), 64'd0);
    check("t2_full_count", 64'(count), 64'd4);
    send(32'h5555_0005, 1'b1);
    send(32'h6666_0006, 1'b1);
    idle(8, 1'b1);

    // 3: zero-length stream
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("t3_done_pulse", 64'(out_done), 64'd1);
    idle(3, 1'b1);

    // 4: done with 3 buffered, consumer toggling, second done while draining
    for (int i = 0; i < 3; i++) send($urandom, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tog = ~tog;
      step(1'b0, '0, (i == 1), 1'b0, tog);
    end

    // 5: flush with a push in the same cycle, then stream 1,4,7,10
    send(32'hAAAA, 1'b0);
    send(32'hBBBB, 1'b0);
    step(1'b1, 32'hCCCC, 1'b1, 1'b1, 1'b0);
    check("t5_flush_count", 64'(count), 64'd0);
    check("t5_flush_valid", 64'(out_valid), 64'd0);
    for (int v = 1; v <= 10; v += 3) send(W'(v), 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);

    // 6: async reset between edges, then repeat test 1
    send(32'd0, 1'b0);
    send(32'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_async_valid", 64'(out_valid), 64'd0);
    check("t6_async_count", 64'(count), 64'd0);
    check("t6_async_done", 64'(out_done), 64'd0);
    check("t6_async_ready", 64'(in_ready), 64'd1);
    check("t6_async_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hrange_0_10_2();

    // Randomized soak against the model
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), $urandom, ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
